// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_if
// Purpose  : EX-stage request/response bundle for the multi-cycle mul/div unit.
// Revision : 1.0
// ============================================================================
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             abort;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, abort,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, abort,
        output busy, stall, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Sequential MULT/MULTU/DIV/DIVU unit (shift-add / restoring) into HI/LO.
//            Optional MULDIV_EARLY_OUT_EN: multiply exits once multiplier bits run out.
// Revision : 1.0
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    muldiv_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed, a_neg, b_neg, accept, early_out, last_step;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod_fix;

    // Signed ops run on magnitudes; the sign flags restore results in FIX.
    assign is_signed = ~bus.op[0];
    assign a_neg     = is_signed & bus.src_a[WIDTH-1];
    assign b_neg     = is_signed & bus.src_b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag     = b_neg ? -bus.src_b : bus.src_b;
    assign accept    = (state_q == S_IDLE) & bus.start & ~bus.abort;

    // Divide layout: acc = {remainder, dividend/quotient}; divisor in opa low half.
    assign rem_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff  = rem_sh - {1'b0, opa_q[WIDTH-1:0]};
    assign quo       = acc_q[WIDTH-1:0];
    assign rem       = acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = ~is_div_q & (mplier_q[WIDTH-1:1] == '0);
`else
    assign early_out = 1'b0;
`endif
    assign last_step = div0_q | (cnt_q == CNT_W'(WIDTH - 1)) | early_out;

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                // Dividend magnitude is still untouched in the quotient slot.
                fix_hi = neg_rem_q ? -quo : quo;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem_q ? -rem : rem;
                fix_lo = neg_res_q ? -quo : quo;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        mplier_d  = mplier_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_CALC;
                    cnt_d     = '0;
                    is_div_d  = bus.op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = bus.op[1] & (bus.src_b == '0);
                    if (bus.op[1]) begin
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opa_d    = {{WIDTH{1'b0}}, b_mag};
                        mplier_d = '0;
                    end else begin
                        acc_d    = '0;
                        opa_d    = {{WIDTH{1'b0}}, a_mag};
                        mplier_d = b_mag;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!div0_q) begin
                    if (is_div_q) begin
                        if (!rem_diff[WIDTH])
                            acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        else
                            acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        // Multiplicand shifts left so an early exit leaves an aligned product.
                        acc_d    = acc_q + (mplier_q[0] ? opa_q : '0);
                        opa_d    = opa_q << 1;
                        mplier_d = mplier_q >> 1;
                    end
                end
                if (last_step)
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_q     <= '0;
            opa_q     <= '0;
            mplier_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            mplier_q  <= mplier_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy  = (state_q == S_CALC) | (state_q == S_FIX);
    assign bus.stall = bus.busy | (bus.start & (state_q == S_IDLE));
    assign bus.done  = (state_q == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule
`default_nettype wire
